// File: rtl/tdm_pkg.sv
// Shared types and sizing helper for the TDM demultiplexer.
// Consumed by tdm_demux and tdm_ch_counter.
package tdm_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Channel counter width; never narrower than one bit.
  function automatic int cnt_width(input int n_ch);
    return (n_ch <= 2) ? 1 : $clog2(n_ch);
  endfunction

endpackage

// File: rtl/tdm_ch_counter.sv
// Modulo-N_CH channel counter with clear, load-to-1 and increment (clear wins).
// Latency 1 cycle; no backpressure, one operation accepted every cycle.
module tdm_ch_counter
  import tdm_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = cnt_width(N_CH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             load1,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  // Explicit wrap so non-power-of-two channel counts never reach N_CH.
  assign wrap = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load1) begin
      cnt <= ONE;
    end else if (inc) begin
      cnt <= wrap ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// Routes a muxed sample stream back to N_CH registered channels, tracking frame lock on sof.
// Latency 1 cycle (sample in t visible in t+1); no backpressure, a sample may arrive every cycle.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W    = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [W-1:0]      din,
  input  logic              din_valid,
  input  logic              sof,
  output logic [N_CH*W-1:0] ch_data,
  output logic [N_CH-1:0]   ch_valid,
  output logic              frame_done,
  output logic              sync_err,
  output logic              locked
);

  localparam int CNT_W = cnt_width(N_CH);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             wrap;
  logic             cnt_zero;
  logic             cnt_clr;
  logic             cnt_load1;
  logic             cnt_inc;

  assign cnt_zero  = (cnt == '0);
  // Any sof sample (re)starts a frame at ch0, whatever the state.
  assign cnt_load1 = din_valid && sof;
  assign cnt_inc   = din_valid && !sof && (state == LOCKED) && !cnt_zero;
  assign cnt_clr   = din_valid && !sof && (state == LOCKED) && cnt_zero;

  tdm_ch_counter #(
    .N_CH  (N_CH),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .load1   (cnt_load1),
    .inc     (cnt_inc),
    .cnt     (cnt),
    .wrap    (wrap)
  );

  assign locked = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= HUNT;
      ch_data    <= '0;
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      if (din_valid) begin
        if (sof) begin
          // Early sof while LOCKED abandons the partial frame without frame_done.
          ch_data[0 +: W] <= din;
          ch_valid[0]     <= 1'b1;
          sync_err        <= (state == LOCKED) && !cnt_zero;
          state           <= LOCKED;
        end else if (state == LOCKED) begin
          if (cnt_zero) begin
            sync_err <= 1'b1;
            state    <= HUNT;
          end else begin
            ch_data[cnt*W +: W] <= din;
            ch_valid[cnt]       <= 1'b1;
            frame_done          <= wrap;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed self-checking bench for tdm_demux with N_CH=4, W=1.
module tb_tdm_demux;

  logic       clk;
  logic       reset_n;
  logic [0:0] din;
  logic       din_valid;
  logic       sof;
  logic [3:0] ch_data;
  logic [3:0] ch_valid;
  logic       frame_done;
  logic       sync_err;
  logic       locked;

  int checks;
  int failures;

  tdm_demux #(.N_CH(4), .W(1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (din),
    .din_valid  (din_valid),
    .sof        (sof),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .locked     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic send(input logic v, input logic d, input logic s);
    @(negedge clk);
    din_valid = v;
    din       = d;
    sof       = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; din_valid = 1'b0; din = 1'b0; sof = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(1'b0, 1'b1, 1'b1);
      checks++;
      if ({ch_data, ch_valid, frame_done, sync_err, locked} !== 11'b0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got data=%b vld=%b fd=%b se=%b lk=%b want all 0",
                 i, ch_data, ch_valid, frame_done, sync_err, locked);
      end
    end
  endtask

  task automatic test_first_frame();
    logic [3:0] samp;
    logic [3:0] exp_vld;
    samp = 4'b1101;  // ch3..ch0 = 1,1,0,1 -> sent as 1,0,1,1
    for (int k = 0; k < 4; k++) begin
      send(1'b1, samp[k], k == 0);
      exp_vld = 4'b0001 << k;
      checks++;
      if (ch_valid !== exp_vld || frame_done !== (k == 3) || locked !== 1'b1 || sync_err !== 1'b0) begin
        failures++;
        $display("FAIL first_frame k=%0d got vld=%b fd=%b lk=%b se=%b want vld=%b fd=%b lk=1 se=0",
                 k, ch_valid, frame_done, locked, sync_err, exp_vld, k == 3);
      end
    end
    checks++;
    if (ch_data !== 4'b1101) begin
      failures++;
      $display("FAIL first_frame_data got %b want 1101", ch_data);
    end
    send(1'b0, 1'b0, 1'b0);
    checks++;
    if (ch_valid !== 4'b0 || frame_done !== 1'b0 || ch_data !== 4'b1101 || locked !== 1'b1) begin
      failures++;
      $display("FAIL strobe_clear got vld=%b fd=%b data=%b lk=%b want 0000 0 1101 1",
               ch_valid, frame_done, ch_data, locked);
    end
  endtask

  task automatic test_clean_frames();
    logic [3:0] frames [3];
    int fd_cnt;
    int se_cnt;
    frames[0] = 4'b0011;  // 1,1,0,0
    frames[1] = 4'b1010;  // 0,1,0,1
    frames[2] = 4'b0001;  // 1,0,0,0
    fd_cnt = 0;
    se_cnt = 0;
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 4; k++) begin
        send(1'b1, frames[f][k], k == 0);
        fd_cnt += int'(frame_done);
        se_cnt += int'(sync_err);
        // Idle cycle with sof high must be ignored.
        send(1'b0, 1'b1, 1'b1);
        fd_cnt += int'(frame_done);
        se_cnt += int'(sync_err);
      end
      checks++;
      if (ch_data !== frames[f]) begin
        failures++;
        $display("FAIL clean_frame_data f=%0d got %b want %b", f, ch_data, frames[f]);
      end
    end
    checks++;
    if (fd_cnt != 3 || se_cnt != 0) begin
      failures++;
      $display("FAIL clean_frames_pulses got fd=%0d se=%0d want fd=3 se=0", fd_cnt, se_cnt);
    end
  endtask

  task automatic test_lost_sync();
    send(1'b1, 1'b1, 1'b0);
    checks++;
    if (sync_err !== 1'b1 || locked !== 1'b0 || ch_valid !== 4'b0 || ch_data !== 4'b0001) begin
      failures++;
      $display("FAIL lost_sync got se=%b lk=%b vld=%b data=%b want 1 0 0000 0001",
               sync_err, locked, ch_valid, ch_data);
    end
    send(1'b1, 1'b1, 1'b0);
    checks++;
    if (sync_err !== 1'b0 || locked !== 1'b0 || ch_valid !== 4'b0 || ch_data !== 4'b0001) begin
      failures++;
      $display("FAIL hunt_discard got se=%b lk=%b vld=%b data=%b want 0 0 0000 0001",
               sync_err, locked, ch_valid, ch_data);
    end
    send(1'b1, 1'b0, 1'b1);
    checks++;
    if (locked !== 1'b1 || ch_valid !== 4'b0001 || ch_data !== 4'b0000 || sync_err !== 1'b0) begin
      failures++;
      $display("FAIL relock got lk=%b vld=%b data=%b se=%b want 1 0001 0000 0",
               locked, ch_valid, ch_data, sync_err);
    end
  endtask

  task automatic test_early_sof();
    int fd_cnt;
    fd_cnt = 0;
    send(1'b1, 1'b1, 1'b0);  // ch1 = 1, cnt -> 2
    fd_cnt += int'(frame_done);
    send(1'b1, 1'b1, 1'b1);  // sof at cnt=2
    fd_cnt += int'(frame_done);
    checks++;
    if (sync_err !== 1'b1 || ch_valid !== 4'b0001 || ch_data[0] !== 1'b1 || locked !== 1'b1 || fd_cnt != 0) begin
      failures++;
      $display("FAIL early_sof got se=%b vld=%b d0=%b lk=%b fd=%0d want 1 0001 1 1 0",
               sync_err, ch_valid, ch_data[0], locked, fd_cnt);
    end
    send(1'b1, 1'b0, 1'b0);
    fd_cnt += int'(frame_done);
    send(1'b1, 1'b0, 1'b0);
    fd_cnt += int'(frame_done);
    checks++;
    if (fd_cnt != 0 || ch_valid !== 4'b0100) begin
      failures++;
      $display("FAIL early_sof_nofd got fd=%0d vld=%b want 0 0100", fd_cnt, ch_valid);
    end
    send(1'b1, 1'b0, 1'b0);
    checks++;
    if (frame_done !== 1'b1 || ch_valid !== 4'b1000 || ch_data !== 4'b0001 || sync_err !== 1'b0) begin
      failures++;
      $display("FAIL early_sof_complete got fd=%b vld=%b data=%b se=%b want 1 1000 0001 0",
               frame_done, ch_valid, ch_data, sync_err);
    end
  endtask

  task automatic test_reset_midframe();
    logic [3:0] samp;
    send(1'b1, 1'b1, 1'b1);
    send(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    reset_n = 1'b0; din_valid = 1'b0; sof = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({ch_data, ch_valid, frame_done, sync_err, locked} !== 11'b0) begin
      failures++;
      $display("FAIL midframe_reset got data=%b vld=%b fd=%b se=%b lk=%b want all 0",
               ch_data, ch_valid, frame_done, sync_err, locked);
    end
    @(negedge clk);
    reset_n = 1'b1;
    send(1'b1, 1'b1, 1'b0);  // evaluated in HUNT: discarded
    checks++;
    if (locked !== 1'b0 || ch_valid !== 4'b0 || ch_data !== 4'b0 || sync_err !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_hunt got lk=%b vld=%b data=%b se=%b want 0 0000 0000 0",
               locked, ch_valid, ch_data, sync_err);
    end
    samp = 4'b0110;  // 0,1,1,0
    for (int k = 0; k < 4; k++) begin
      send(1'b1, samp[k], k == 0);
      checks++;
      if (ch_valid !== (4'b0001 << k) || frame_done !== (k == 3) || sync_err !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_frame k=%0d got vld=%b fd=%b se=%b", k, ch_valid, frame_done, sync_err);
      end
    end
    checks++;
    if (ch_data !== 4'b0110 || locked !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_data got data=%b lk=%b want 0110 1", ch_data, locked);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_first_frame();
    test_clean_frames();
    test_lost_sync();
    test_early_sof();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
